serial_subtractor: RTL

//  Multi-cycle WIDTH-bit subtractor: diff = a - b - borrow_in, computed LSB-first DIGIT bits/cycle

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle LSB-first subtractor: diff = a - b - borrow_in, DIGIT bits per cycle.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NSLICE = WIDTH / DIGIT;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   generate
      if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             bchain_q, bchain_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic             zero_q, zero_d;
`ifdef SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [DIGIT-1:0] a_s, b_s, d_s;
   logic             bo;

   // One DIGIT-wide slice, reused every RUN cycle; the extra top bit is the borrow out.
   assign a_s = a_q[cnt_q*DIGIT +: DIGIT];
   assign b_s = b_q[cnt_q*DIGIT +: DIGIT];
   assign {bo, d_s} = {1'b0, a_s} - {1'b0, b_s} - (DIGIT+1)'(bchain_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      bchain_d = bchain_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
`ifdef SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               bchain_d = borrow_in;
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            res_d[cnt_q*DIGIT +: DIGIT] = d_s;
            bchain_d = bo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d  = StDone;
               borrow_d = bo;
               zero_d   = (res_d == '0);
`ifdef SUB_OVF_EN
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         bchain_q <= 1'b0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         bchain_q <= bchain_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
`ifdef SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign diff      = res_q;
   assign borrow    = borrow_q;
   assign zero      = zero_q;
`ifdef SUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
